// File: rtl/vga_gfx_pkg.sv
// Shared constants for the VGA graphics path: colour key, default geometry
// and a constant-foldable ceil(log2) helper.
package vga_gfx_pkg;

  localparam logic [7:0] DEF_TRANSPARENT = 8'hFC;

  localparam int DEF_N_SPR       = 32'sd4;
  localparam int DEF_LEFT        = 32'sd155;
  localparam int DEF_BG_W        = 32'sd330;
  localparam int DEF_BG_H        = 32'sd480;
  localparam int DEF_SCALE_SHIFT = 32'sd1;
  localparam int DEF_BG_SRC_W    = 32'sd165;
  localparam int DEF_BG_AW       = 32'sd16;
  localparam int DEF_SPR_W       = 32'sd21;
  localparam int DEF_SPR_H       = 32'sd19;
  localparam int DEF_FRAMES      = 32'sd2;
  localparam int DEF_SPR_AW      = 32'sd10;
  localparam int DEF_ANIM_DIV    = 32'sd8;

  function automatic int clog2(input int value);
    int result_v;
    int acc_v;
    result_v = 32'sd0;
    acc_v    = 32'sd1;
    while (acc_v < value) begin
      acc_v    = acc_v * 32'sd2;
      result_v = result_v + 32'sd1;
    end
    return result_v;
  endfunction

endpackage

// File: rtl/sprite_layer_compositor_if.sv
// ROM fetch bus between the compositor (master) and the background/sprite
// ROMs (slave); ROM data returns one clock after the address.
interface sprite_layer_compositor_if #(
  parameter int N_SPR  = 4,
  parameter int BG_AW  = 16,
  parameter int SPR_AW = 10
);
  logic [BG_AW-1:0]        bg_addr;
  logic [7:0]              bg_data;
  logic [N_SPR*SPR_AW-1:0] spr_addr;
  logic [N_SPR*8-1:0]      spr_data;

  modport master (output bg_addr, output spr_addr, input bg_data, input spr_data);
  modport slave  (input bg_addr, input spr_addr, output bg_data, output spr_data);
endinterface

// File: rtl/sprite_layer_compositor_sprite_hit_addr.sv
// One sprite layer: window hit test on the source-space pixel and the
// registered ROM address including the animation frame offset.
module sprite_hit_addr
  import vga_gfx_pkg::*;
#(
  parameter int SPR_W  = DEF_SPR_W,
  parameter int SPR_H  = DEF_SPR_H,
  parameter int SPR_AW = DEF_SPR_AW,
  parameter int AFW    = 1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        x_bg,
  input  logic [7:0]        y_bg,
  input  logic [7:0]        spr_x,
  input  logic [7:0]        spr_y,
  input  logic              en,
  input  logic              bg_on,
  input  logic [AFW-1:0]    anim_frame,
  output logic              hit_r,
  output logic [SPR_AW-1:0] addr_r
);

  logic [8:0]        x_end_s;
  logic [8:0]        y_end_s;
  logic [7:0]        dx_s;
  logic [7:0]        dy_s;
  logic              hit_s;
  logic [SPR_AW-1:0] addr_s;

  // Window ends are 9 bits wide so a sprite placed near 255 never wraps to 0
  always_comb begin
    x_end_s = {1'b0, spr_x} + 9'(SPR_W);
    y_end_s = {1'b0, spr_y} + 9'(SPR_H);
    hit_s   = bg_on && en &&
              (x_bg >= spr_x) && ({1'b0, x_bg} < x_end_s) &&
              (y_bg >= spr_y) && ({1'b0, y_bg} < y_end_s);
    dx_s    = x_bg - spr_x;
    dy_s    = y_bg - spr_y;
    if (hit_s) begin
      addr_s = SPR_AW'(anim_frame) * SPR_AW'(SPR_W * SPR_H)
             + SPR_AW'(dy_s) * SPR_AW'(SPR_W)
             + SPR_AW'(dx_s);
    end else begin
      addr_s = {SPR_AW{1'b0}};
    end
  end

  // Stage 1 register for this layer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_r  <= 1'b0;
      addr_r <= {SPR_AW{1'b0}};
    end else begin
      hit_r  <= hit_s;
      addr_r <= addr_s;
    end
  end

endmodule

// File: rtl/sprite_layer_compositor.sv
// Background + N_SPR sprite compositor with colour-key transparency and
// frame-tick animation; 2 clocks from x_ptr/y_ptr sample to RGB.
module sprite_layer_compositor
  import vga_gfx_pkg::*;
#(
  parameter int         N_SPR       = DEF_N_SPR,
  parameter int         LEFT        = DEF_LEFT,
  parameter int         BG_W        = DEF_BG_W,
  parameter int         BG_H        = DEF_BG_H,
  parameter int         SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int         BG_SRC_W    = DEF_BG_SRC_W,
  parameter int         BG_AW       = DEF_BG_AW,
  parameter int         SPR_W       = DEF_SPR_W,
  parameter int         SPR_H       = DEF_SPR_H,
  parameter int         FRAMES      = DEF_FRAMES,
  parameter int         SPR_AW      = DEF_SPR_AW,
  parameter int         ANIM_DIV    = DEF_ANIM_DIV,
  parameter logic [7:0] TRANSPARENT = DEF_TRANSPARENT,
  localparam int        AFW  = (clog2(FRAMES) > 32'sd0) ? clog2(FRAMES) : 32'sd1,
  localparam int        DIVW = (clog2(ANIM_DIV) > 32'sd0) ? clog2(ANIM_DIV) : 32'sd1
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [9:0]              x_ptr,
  input  logic [9:0]              y_ptr,
  input  logic                    pix_valid,
  input  logic                    frame_tick,
  input  logic [N_SPR-1:0]        sprite_en,
  input  logic [N_SPR*8-1:0]      sprite_x,
  input  logic [N_SPR*8-1:0]      sprite_y,
  sprite_layer_compositor_if.master rom,
  output logic [AFW-1:0]          anim_frame,
  output logic [7:0]              RGB,
  output logic                    rgb_valid
);

  logic                    bg_on_s;
  logic [9:0]              x_off_s;
  logic [7:0]              x_bg_s;
  logic [7:0]              y_bg_s;
  logic [BG_AW-1:0]        bg_addr_s;
  logic [7:0]              rgb_s;

  logic [BG_AW-1:0]        bg_addr_r;
  logic                    bg_on_r;
  logic                    pv_r;
  logic [N_SPR-1:0]        hit_r;
  logic [N_SPR*SPR_AW-1:0] spr_addr_r;
  logic                    bg_on_d_r;
  logic                    pv_d_r;
  logic [N_SPR-1:0]        hit_d_r;
  logic [7:0]              rgb_r;
  logic                    rgb_valid_r;
  logic [AFW-1:0]          anim_frame_r;
  logic [DIVW-1:0]         anim_div_r;

  // Stage 1 geometry: bounds are compared before subtracting LEFT so left-of-window never wraps
  always_comb begin
    bg_on_s = pix_valid &&
              ({1'b0, x_ptr} >= 11'(LEFT)) && ({1'b0, x_ptr} < 11'(LEFT + BG_W)) &&
              ({1'b0, y_ptr} < 11'(BG_H));
    if (bg_on_s) begin
      x_off_s = x_ptr - 10'(LEFT);
    end else begin
      x_off_s = 10'd0;
    end
    x_bg_s = 8'(x_off_s >> SCALE_SHIFT);
    y_bg_s = 8'(y_ptr >> SCALE_SHIFT);
    if (bg_on_s) begin
      bg_addr_s = BG_AW'(y_bg_s) * BG_AW'(BG_SRC_W) + BG_AW'(x_bg_s);
    end else begin
      bg_addr_s = {BG_AW{1'b0}};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_SPR; gi++) begin : g_spr
      sprite_hit_addr #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .SPR_AW (SPR_AW),
        .AFW    (AFW)
      ) u_hit (
        .clk        (clk),
        .rst_n      (rst_n),
        .x_bg       (x_bg_s),
        .y_bg       (y_bg_s),
        .spr_x      (sprite_x[gi*8 +: 8]),
        .spr_y      (sprite_y[gi*8 +: 8]),
        .en         (sprite_en[gi]),
        .bg_on      (bg_on_s),
        .anim_frame (anim_frame_r),
        .hit_r      (hit_r[gi]),
        .addr_r     (spr_addr_r[gi*SPR_AW +: SPR_AW])
      );
    end
  endgenerate

  // Stage 1: background address and pixel flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_addr_r <= {BG_AW{1'b0}};
      bg_on_r   <= 1'b0;
      pv_r      <= 1'b0;
    end else begin
      bg_addr_r <= bg_addr_s;
      bg_on_r   <= bg_on_s;
      pv_r      <= pix_valid;
    end
  end

  // Stage 2: flags wait one clock while the ROMs look up their data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_on_d_r <= 1'b0;
      pv_d_r    <= 1'b0;
      hit_d_r   <= {N_SPR{1'b0}};
    end else begin
      bg_on_d_r <= bg_on_r;
      pv_d_r    <= pv_r;
      hit_d_r   <= hit_r;
    end
  end

  // Priority mux: walking down from the lowest layer lets layer 0 win; keyed pixels fall through
  always_comb begin
    rgb_s = bg_on_d_r ? rom.bg_data : 8'h00;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      rgb_s = (hit_d_r[i] && (rom.spr_data[i*8 +: 8] != TRANSPARENT)) ?
              rom.spr_data[i*8 +: 8] : rgb_s;
    end
  end

  // Stage 3: composited output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_r       <= 8'h00;
      rgb_valid_r <= 1'b0;
    end else begin
      rgb_r       <= rgb_s;
      rgb_valid_r <= pv_d_r;
    end
  end

  // Animation: ANIM_DIV frame ticks per step; the pixel sampled on the stepping tick keeps the old frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anim_div_r   <= {DIVW{1'b0}};
      anim_frame_r <= {AFW{1'b0}};
    end else if (frame_tick) begin
      if (anim_div_r == DIVW'(ANIM_DIV - 1)) begin
        anim_div_r <= {DIVW{1'b0}};
        if (anim_frame_r == AFW'(FRAMES - 1)) begin
          anim_frame_r <= {AFW{1'b0}};
        end else begin
          anim_frame_r <= anim_frame_r + {{(AFW-1){1'b0}}, 1'b1};
        end
      end else begin
        anim_div_r <= anim_div_r + {{(DIVW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign rom.bg_addr  = bg_addr_r;
  assign rom.spr_addr = spr_addr_r;
  assign anim_frame   = anim_frame_r;
  assign RGB          = rgb_r;
  assign rgb_valid    = rgb_valid_r;

endmodule

// File: tb/tb_sprite_layer_compositor.sv
// Scoreboard bench for sprite_layer_compositor: a reference model pushes the
// expected address/pixel per driven pixel; outputs are checked 1 and 2 clocks later.
module tb_sprite_layer_compositor;
  import vga_gfx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  x_ptr;
  logic [9:0]  y_ptr;
  logic        pix_valid;
  logic        frame_tick;
  logic [3:0]  sprite_en;
  logic [31:0] sprite_x;
  logic [31:0] sprite_y;
  logic [0:0]  anim_frame;
  logic [7:0]  RGB;
  logic        rgb_valid;

  sprite_layer_compositor_if #(.N_SPR(4), .BG_AW(16), .SPR_AW(10)) rom ();

  sprite_layer_compositor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x_ptr      (x_ptr),
    .y_ptr      (y_ptr),
    .pix_valid  (pix_valid),
    .frame_tick (frame_tick),
    .sprite_en  (sprite_en),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .rom        (rom.master),
    .anim_frame (anim_frame),
    .RGB        (RGB),
    .rgb_valid  (rgb_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       v;
    logic [7:0] rgb;
  } out_t;

  out_t       rgb_q[$];
  logic [7:0] spr_mem [4][1024];
  logic [15:0] exp_bg;
  logic [9:0]  exp_spr [4];
  int          m_frame;
  int          m_div;

  function automatic logic [7:0] bg_rom(input logic [15:0] a);
    return 8'h25 ^ a[7:0] ^ a[15:8];
  endfunction

  // Synchronous ROMs, one clock of latency
  always @(posedge clk) begin
    rom.bg_data <= bg_rom(rom.bg_addr);
    for (int i = 0; i < 4; i++)
      rom.spr_data[i*8 +: 8] <= spr_mem[i][rom.spr_addr[i*10 +: 10]];
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    out_t z;
    rst_n = 1'b0;
    x_ptr = 10'd0; y_ptr = 10'd0; pix_valid = 1'b0; frame_tick = 1'b0;
    m_frame = 0; m_div = 0;
    rgb_q.delete();
    z.v = 1'b0; z.rgb = 8'h00;
    rgb_q.push_back(z);
    rgb_q.push_back(z);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one pixel, predict its outputs, clock once and check.
  task automatic step(input int x, input int y, input logic pv, input logic tick);
    int xb, yb, sx, sy;
    logic on;
    logic [7:0] pix, d;
    out_t e;
    x_ptr = 10'(x); y_ptr = 10'(y); pix_valid = pv; frame_tick = tick;
    on = pv && (x >= 155) && (x < 485) && (y < 480);
    xb = on ? (x - 155) >> 1 : 0;
    yb = on ? y >> 1 : 0;
    exp_bg = on ? 16'(yb * 165 + xb) : 16'd0;
    pix = on ? bg_rom(exp_bg) : 8'h00;
    for (int i = 3; i >= 0; i--) begin
      sx = int'(sprite_x[i*8 +: 8]);
      sy = int'(sprite_y[i*8 +: 8]);
      if (on && sprite_en[i] && xb >= sx && xb < sx + 21 && yb >= sy && yb < sy + 19) begin
        exp_spr[i] = 10'(m_frame * 399 + (yb - sy) * 21 + (xb - sx));
        d = spr_mem[i][exp_spr[i]];
        if (d != 8'hFC) pix = d;
      end else begin
        exp_spr[i] = 10'd0;
      end
    end
    e.v = pv; e.rgb = pix;
    rgb_q.push_back(e);
    @(posedge clk);
    #1;
    if (tick) begin
      if (m_div == 7) begin
        m_div = 0;
        m_frame = (m_frame + 1) % 2;
      end else begin
        m_div++;
      end
    end
    chk_eq("bg_addr", 32'(rom.bg_addr), 32'(exp_bg));
    for (int i = 0; i < 4; i++)
      chk_eq($sformatf("spr_addr%0d", i), 32'(rom.spr_addr[i*10 +: 10]), 32'(exp_spr[i]));
    chk_eq("anim_frame", 32'(anim_frame), 32'(m_frame));
    e = rgb_q.pop_front();
    chk_eq("rgb_valid", 32'(rgb_valid), 32'(e.v));
    chk_eq("RGB", 32'(RGB), 32'(e.rgb));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++)
      for (int a = 0; a < 1024; a++)
        spr_mem[i][a] = 8'(a * 3 + i * 61 + 5);
    sprite_en = 4'b0000; sprite_x = 32'd0; sprite_y = 32'd0;
    rom.bg_data = 8'h00; rom.spr_data = 32'd0;

    apply_reset();
    chk_eq("reset_bg_addr", 32'(rom.bg_addr), 32'd0);
    chk_eq("reset_spr_addr", 32'(rom.spr_addr), 32'd0);
    chk_eq("reset_RGB", 32'(RGB), 32'd0);
    chk_eq("reset_rgb_valid", 32'(rgb_valid), 32'd0);
    chk_eq("reset_anim", 32'(anim_frame), 32'd0);

    // Left edge of background, then left of it
    step(155, 0, 1'b1, 1'b0);
    step(100, 10, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    chk_eq("bg_left_rgb", 32'(RGB), 32'h25);
    idle(2);

    // Single sprite
    sprite_x[7:0] = 8'd72; sprite_y[7:0] = 8'd112; sprite_en = 4'b0001;
    spr_mem[0][22] = 8'h1C;
    step(155 + 2 * 73, 2 * 113, 1'b1, 1'b0);
    chk_eq("spr0_addr_22", 32'(rom.spr_addr[9:0]), 32'd22);
    idle(2);
    chk_eq("spr0_rgb", 32'(RGB), 32'h1C);

    // Overlap: transparent top layer falls through, opaque top layer wins
    sprite_x[15:8] = 8'd70; sprite_y[15:8] = 8'd110; sprite_en = 4'b0011;
    spr_mem[0][22] = 8'hFC; spr_mem[1][66] = 8'h03;
    step(301, 226, 1'b1, 1'b0);
    idle(2);
    chk_eq("overlap_fall", 32'(RGB), 32'h03);
    spr_mem[0][22] = 8'hE0;
    step(301, 226, 1'b1, 1'b0);
    idle(2);
    chk_eq("overlap_top", 32'(RGB), 32'hE0);

    // Scan across both sprite edges, then window boundaries
    for (int x = 280; x < 340; x++) step(x, 226, 1'b1, 1'b0);
    step(484, 479, 1'b1, 1'b0);
    step(485, 479, 1'b1, 1'b0);
    step(154, 0, 1'b1, 1'b0);
    step(200, 480, 1'b1, 1'b0);
    step(300, 226, 1'b0, 1'b0);

    // Sprites near 255 must not wrap onto x_bg/y_bg = 5/0
    sprite_x[23:16] = 8'd250; sprite_y[23:16] = 8'd0;
    sprite_x[31:24] = 8'd0;   sprite_y[31:24] = 8'd250;
    sprite_en = 4'b1111;
    step(165, 0, 1'b1, 1'b0);
    chk_eq("nowrap_x", 32'(rom.spr_addr[29:20]), 32'd0);
    chk_eq("nowrap_y", 32'(rom.spr_addr[39:30]), 32'd0);
    idle(2);
    chk_eq("nowrap_rgb", 32'(RGB), 32'(bg_rom(16'd5)));

    // Animation: 16 ticks
    sprite_en = 4'b0001;
    spr_mem[0][22] = 8'h1C;
    for (int t = 1; t <= 16; t++) begin
      step(301, 226, 1'b1, 1'b1);
      if (t == 8) chk_eq("anim_t8", 32'(anim_frame), 32'd1);
      if (t == 16) chk_eq("anim_t16", 32'(anim_frame), 32'd0);
      step(301, 226, 1'b1, 1'b0);
      if (t == 8) chk_eq("spr0_addr_f1", 32'(rom.spr_addr[9:0]), 32'd421);
    end

    // Partial divider count, then reset mid-line
    for (int t = 0; t < 3; t++) step(301, 226, 1'b1, 1'b1);
    step(302, 226, 1'b1, 1'b0);
    step(303, 226, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk_eq("midreset_RGB", 32'(RGB), 32'd0);
    chk_eq("midreset_valid", 32'(rgb_valid), 32'd0);
    chk_eq("midreset_bg_addr", 32'(rom.bg_addr), 32'd0);
    apply_reset();
    step(0, 0, 1'b0, 1'b0);
    step(301, 226, 1'b1, 1'b0);
    step(302, 226, 1'b1, 1'b0);
    step(303, 226, 1'b1, 1'b0);
    idle(2);

    // Divider restarted from 0: toggle on the 8th tick after reset
    for (int t = 0; t < 8; t++) step(160, 4, 1'b1, 1'b1);
    chk_eq("anim_after_reset", 32'(anim_frame), 32'd1);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
